int_ctrl: RTL and testbench
===========================

# int_ctrl

Interrupt/exception controller that drives the program counter's redirect inputs (`int_signal`, `SEPC`, `ERET`, `ERETN`). It latches external interrupt edges, arbitrates them against the mask and global enable, and accepts a trap only at a committed instruction boundary. On acceptance it captures the resume address into `SEPC`, then gates return requests from the decode stage. It also exposes a small CP0-style register file (Status/Cause/EPC) to the datapath.

## Interface
- `NIRQ`, 6: number of external interrupt lines (1..8).
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `irq` input NIRQ: external interrupt request levels; rising edges are latched.
- `pc_cur` input 32: address of the instruction committing this cycle.
- `inst_valid` input 1: an instruction commits this cycle; traps are accepted only when high.
- `syscall` input 1: the committing instruction is a syscall (qualified by `inst_valid`).
- `eret_req` input 1: decode requests return-to-SEPC.
- `eretn_req` input 1: decode requests return-to-SEPC+4.
- `cp0_we` input 1: register write strobe.
- `cp0_addr` input 5: register select: 12 Status, 13 Cause, 14 EPC.
- `cp0_wdata` input 32: write data.
- `cp0_rdata` output 32: combinational read of `cp0_addr`; 0 for unmapped addresses.
- `int_signal` output 1: trap taken this cycle; PC loads vector 0x000000CC at the next edge.
- `SEPC` output 32: saved exception PC (EPC register).
- `ERET` output 1: qualified return pulse.
- `ERETN` output 1: qualified return pulse; resume address is SEPC+4.

## Operation
- Registers:
  - Status: IE = bit0; IM[NIRQ-1:0] = bits[8+NIRQ-1:8]; all other bits read 0.
  - Cause: IP = bits[8+NIRQ-1:8]; ExcCode = bits[6:2] (0 interrupt, 8 syscall); IRQ index = bits[18:16].
  - EPC: 32 bits, drives `SEPC`.
- Edge detect: `irq_q` holds the previous `irq`. A rising edge (`irq & ~irq_q`) sets IP[i].
- Pending: `pend = IP & IM`.
- FSM `RUN` / `HANDLER`:
  - `RUN`: the trap condition is `inst_valid & (syscall | (IE & |pend))`. `int_signal` is combinational and equals this condition while in `RUN`. It is 0 while in `HANDLER`.
  - Trap taken at the edge:
    - EPC <= `pc_cur`.
    - IE <= 0.
    - State -> `HANDLER`.
    - If `syscall`: ExcCode <= 8; IP is unchanged.
    - Otherwise: ExcCode <= 0; IRQ index <= the lowest set bit of `pend`; that IP bit is cleared (auto-acknowledge).
  - Syscall has priority over interrupts and is taken regardless of IE.
  - `HANDLER`:
    - `ERET = eret_req`; `ERETN = eretn_req & ~eret_req` (ERET wins if both are asserted).
    - On either pulse: IE <= 1, state -> `RUN`.
    - `syscall` and interrupts are ignored; IP keeps latching edges.
  - In `RUN`, `ERET`/`ERETN` are forced to 0.
- Software writes (`cp0_we`):
  - Status: writes IE and IM.
  - Cause: writes only IP; a 0 written to a bit clears it.
  - EPC: writes the full word.
- Write collisions (the hardware event wins on the same field):
  - A new edge overrides a software clear of the same IP bit.
  - A trap's IE<=0 overrides a Status write.
  - A return's IE<=1 overrides a Status write.
  - A trap's EPC capture overrides an EPC write.

## Timing
- Reset values:
  - State `RUN`; IE=0; IM=0; IP=0; ExcCode=0; IRQ index=0; EPC=0; `irq_q`=0.
  - Outputs `int_signal`=0, `ERET`=0, `ERETN`=0, `SEPC`=0.
- `rst` is sampled at the edge and overrides every other input, including a trap or return in the same cycle.
- Interrupt latency:
  - The `irq` edge is sampled at edge N, so IP is set after N.
  - `int_signal` can assert in cycle N+1 if `inst_valid`, IE and IM allow it.
  - PC is at 0xCC after edge N+2.
- `int_signal` is at most a one-cycle pulse per trap, because the state leaves `RUN` at the same edge.
- `cp0_rdata` reflects register contents before the current-cycle write. There is no write-through bypass.
- An `irq` level held high produces only one pending event; it must drop and rise again to re-pend.

## Test plan
- After reset: `cp0_rdata` is 0 for addresses 12, 13 and 14; all outputs are 0. Assert `eret_req` in `RUN` -> `ERET` stays 0.
- Basic interrupt:
  - Stimulus: write Status=0x0000_0201 (IE=1, IM[1]=1). Raise `irq[1]`. One cycle later, `inst_valid=1` with `pc_cur`=0x0000_0040.
  - Required: `int_signal`=1 for exactly one cycle; then `SEPC`=0x40, Cause=0x0001_0000, IE=0.
  - Then `eret_req` -> `ERET`=1 for one cycle and IE=1.
- Masking and priority:
  - Raise `irq[3]` and `irq[0]` together with IM=0x08 -> only bit 3 is taken; IP[0] remains pending.
  - After return, set IM=0x09 -> the next committing instruction traps with IRQ index 0.
- Syscall:
  - Stimulus: IE=0; `syscall=1` and `inst_valid=1` at `pc_cur`=0x100.
  - Required: `int_signal`=1, ExcCode=8, `SEPC`=0x100.
  - `eretn_req` -> `ERETN`=1. Asserting `eret_req` and `eretn_req` together instead -> only `ERET`=1.
- Collisions:
  - A Cause write clearing IP[2] in the same cycle as a new `irq[2]` edge -> IP[2]=1.
  - A Status write of IE=1 in the trap cycle -> IE=0.
  - `rst` asserted in `HANDLER` with `eret_req` high -> `ERET`=0, all registers return to reset values.
- Held level: hold `irq[4]` high across two trap/return sequences -> exactly one trap occurs.

Source files
------------

// File: rtl/int_ctrl.sv
// Interrupt/exception controller: latches irq edges, takes traps at commit boundaries,
// and qualifies return requests from decode. Exposes Status/Cause/EPC as a small CP0 file.
module int_ctrl #(
    parameter int NIRQ = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq,
    input  logic [31:0]     pc_cur,
    input  logic            inst_valid,
    input  logic            syscall,
    input  logic            eret_req,
    input  logic            eretn_req,
    input  logic            cp0_we,
    input  logic [4:0]      cp0_addr,
    input  logic [31:0]     cp0_wdata,
    output logic [31:0]     cp0_rdata,
    output logic            int_signal,
    output logic [31:0]     SEPC,
    output logic            ERET,
    output logic            ERETN
);

    typedef enum logic {RUN, HANDLER} state_t;

    state_t          state_q, state_d;
    logic            ie_q, ie_d;
    logic [NIRQ-1:0] im_q, im_d;
    logic [NIRQ-1:0] ip_q, ip_d;
    logic [4:0]      exc_code_q, exc_code_d;
    logic [2:0]      irq_idx_q, irq_idx_d;
    logic [31:0]     epc_q, epc_d;
    logic [NIRQ-1:0] irq_prev_q, irq_prev_d;

    logic [NIRQ-1:0] pend;
    logic [NIRQ-1:0] pend_lowest;
    logic [NIRQ-1:0] irq_rise;
    logic [2:0]      low_idx;
    logic            in_run;
    logic            take_trap;
    logic            eret_ok;
    logic            eretn_ok;
    logic            take_ret;
    logic            wr_status;
    logic            wr_cause;
    logic            wr_epc;
    logic            wdata_unused;

    assign wdata_unused = ^cp0_wdata;

    always_comb begin
        pend        = ip_q & im_q;
        pend_lowest = pend & (~pend + NIRQ'(1));
        irq_rise    = irq & ~irq_prev_q;
        low_idx     = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                low_idx = 3'(i);
            end
        end

        in_run    = (state_q == RUN);
        take_trap = in_run & inst_valid & (syscall | (ie_q & |pend));
        eret_ok   = ~in_run & eret_req;
        eretn_ok  = ~in_run & eretn_req & ~eret_req;
        take_ret  = eret_ok | eretn_ok;

        wr_status = cp0_we & (cp0_addr == 5'd12);
        wr_cause  = cp0_we & (cp0_addr == 5'd13);
        wr_epc    = cp0_we & (cp0_addr == 5'd14);

        // Reset wins over everything in its cycle, so no redirect escapes to the PC.
        int_signal = take_trap & ~rst;
        ERET       = eret_ok & ~rst;
        ERETN      = eretn_ok & ~rst;
        SEPC       = epc_q;
    end

    // Software writes first, then hardware events layered on top so they win collisions.
    always_comb begin
        state_d    = state_q;
        ie_d       = ie_q;
        im_d       = im_q;
        ip_d       = ip_q;
        exc_code_d = exc_code_q;
        irq_idx_d  = irq_idx_q;
        epc_d      = epc_q;
        irq_prev_d = irq;

        if (wr_status) begin
            ie_d = cp0_wdata[0];
            im_d = cp0_wdata[8 +: NIRQ];
        end
        if (wr_cause) begin
            ip_d = cp0_wdata[8 +: NIRQ];
        end
        if (wr_epc) begin
            epc_d = cp0_wdata;
        end

        if (take_trap) begin
            state_d = HANDLER;
            ie_d    = 1'b0;
            epc_d   = pc_cur;
            if (syscall) begin
                exc_code_d = 5'd8;
            end else begin
                exc_code_d = 5'd0;
                irq_idx_d  = low_idx;
                ip_d       = ip_d & ~pend_lowest;
            end
        end else if (take_ret) begin
            state_d = RUN;
            ie_d    = 1'b1;
        end

        ip_d = ip_d | irq_rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            ie_q       <= 1'b0;
            im_q       <= '0;
            ip_q       <= '0;
            exc_code_q <= '0;
            irq_idx_q  <= '0;
            epc_q      <= '0;
            irq_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            ie_q       <= ie_d;
            im_q       <= im_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            irq_idx_q  <= irq_idx_d;
            epc_q      <= epc_d;
            irq_prev_q <= irq_prev_d;
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            5'd12: begin
                cp0_rdata[0]        = ie_q;
                cp0_rdata[8 +: NIRQ] = im_q;
            end
            5'd13: begin
                cp0_rdata[8 +: NIRQ] = ip_q;
                cp0_rdata[6:2]       = exc_code_q;
                cp0_rdata[18:16]     = irq_idx_q;
            end
            5'd14: cp0_rdata = epc_q;
            default: cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed testbench for int_ctrl: reset state, interrupt and syscall traps, masking,
// return qualification, write collisions and held-level behaviour.
module tb_int_ctrl;

   localparam int NIRQ = 6;

   logic            clock;
   logic            reset;
   logic [NIRQ-1:0] irq;
   logic [31:0]     pcCur;
   logic            instValid;
   logic            syscall;
   logic            eretReq;
   logic            eretnReq;
   logic            cp0We;
   logic [4:0]      cp0Addr;
   logic [31:0]     cp0Wdata;
   logic [31:0]     cp0Rdata;
   logic            intSignal;
   logic [31:0]     sepc;
   logic            eret;
   logic            eretn;

   int vectorCount = 0;
   int missCount   = 0;

   int_ctrl #(.NIRQ(NIRQ)) dut (
      .clk        (clock),
      .rst        (reset),
      .irq        (irq),
      .pc_cur     (pcCur),
      .inst_valid (instValid),
      .syscall    (syscall),
      .eret_req   (eretReq),
      .eretn_req  (eretnReq),
      .cp0_we     (cp0We),
      .cp0_addr   (cp0Addr),
      .cp0_wdata  (cp0Wdata),
      .cp0_rdata  (cp0Rdata),
      .int_signal (intSignal),
      .SEPC       (sepc),
      .ERET       (eret),
      .ERETN      (eretn)
   );

   // 10 ns free-running clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point: counts every vector and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectorCount++;
      if (got !== exp) begin
         missCount++;
         $display("[TB] FAIL %s got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clearInputs();
      pcCur     = '0;
      instValid = 1'b0;
      syscall   = 1'b0;
      eretReq   = 1'b0;
      eretnReq  = 1'b0;
      cp0We     = 1'b0;
      cp0Addr   = '0;
      cp0Wdata  = '0;
   endtask

   // Drive the commit/decode side for the current cycle
   task automatic applyStimulus(input logic iv, input logic sc, input logic [31:0] pc,
                                input logic er, input logic ern);
      instValid = iv;
      syscall   = sc;
      pcCur     = pc;
      eretReq   = er;
      eretnReq  = ern;
   endtask

   task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
      cp0We    = 1'b1;
      cp0Addr  = a;
      cp0Wdata = d;
      tick();
      cp0We    = 1'b0;
   endtask

   task automatic checkReg(input string tag, input logic [4:0] a, input logic [31:0] exp);
      cp0Addr = a;
      #1;
      checkOutput(tag, cp0Rdata, exp);
   endtask

   task automatic checkBit(input string tag, input logic got, input logic exp);
      checkOutput(tag, {31'd0, got}, {31'd0, exp});
   endtask

   // Main directed sequence
   initial begin
      reset = 1'b1;
      irq   = '0;
      clearInputs();
      tick();
      tick();
      reset = 1'b0;

      checkReg("rst_status", 5'd12, 32'h0);
      checkReg("rst_cause", 5'd13, 32'h0);
      checkReg("rst_epc", 5'd14, 32'h0);
      checkBit("rst_int", intSignal, 1'b0);
      checkBit("rst_eret", eret, 1'b0);
      checkBit("rst_eretn", eretn, 1'b0);
      checkOutput("rst_sepc", sepc, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      checkBit("run_eret_blocked", eret, 1'b0);
      tick();
      clearInputs();
      checkReg("run_eret_ie", 5'd12, 32'h0);

      writeReg(5'd12, 32'h0000_0201);
      checkReg("bas_status", 5'd12, 32'h0000_0201);
      irq = 6'b000010;
      tick();
      checkReg("bas_ip", 5'd13, 32'h0000_0200);
      checkBit("bas_noiv", intSignal, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h40, 1'b0, 1'b0);
      #1;
      checkBit("bas_int", intSignal, 1'b1);
      tick();
      checkBit("bas_int_pulse", intSignal, 1'b0);
      clearInputs();
      checkOutput("bas_sepc", sepc, 32'h40);
      checkReg("bas_cause", 5'd13, 32'h0001_0000);
      checkReg("bas_ie_off", 5'd12, 32'h0000_0200);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      checkBit("bas_eret", eret, 1'b1);
      tick();
      checkBit("bas_eret_pulse", eret, 1'b0);
      clearInputs();
      checkReg("bas_ie_on", 5'd12, 32'h0000_0201);
      irq = '0;
      tick();

      writeReg(5'd12, 32'h0000_0801);
      irq = 6'b001001;
      tick();
      checkReg("msk_ip", 5'd13, 32'h0001_0900);
      applyStimulus(1'b1, 1'b0, 32'h80, 1'b0, 1'b0);
      #1;
      checkBit("msk_int", intSignal, 1'b1);
      tick();
      clearInputs();
      checkReg("msk_cause3", 5'd13, 32'h0003_0100);
      checkOutput("msk_sepc", sepc, 32'h80);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      clearInputs();
      checkReg("msk_ret_ie", 5'd12, 32'h0000_0801);
      applyStimulus(1'b1, 1'b0, 32'h84, 1'b0, 1'b0);
      #1;
      checkBit("msk_blocked", intSignal, 1'b0);
      clearInputs();
      writeReg(5'd12, 32'h0000_0901);
      applyStimulus(1'b1, 1'b0, 32'h88, 1'b0, 1'b0);
      #1;
      checkBit("msk_int0", intSignal, 1'b1);
      tick();
      clearInputs();
      checkReg("msk_cause0", 5'd13, 32'h0000_0000);
      checkOutput("msk_sepc0", sepc, 32'h88);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      #1;
      checkBit("msk_eretn", eretn, 1'b1);
      checkBit("msk_eretn_eret", eret, 1'b0);
      tick();
      clearInputs();
      irq = '0;
      tick();

      writeReg(5'd12, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
      #1;
      checkBit("sys_int", intSignal, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b1, 32'h104, 1'b0, 1'b0);
      #1;
      checkBit("sys_hdl_ignore", intSignal, 1'b0);
      clearInputs();
      checkReg("sys_cause", 5'd13, 32'h0000_0020);
      checkOutput("sys_sepc", sepc, 32'h100);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      #1;
      checkBit("sys_eretn", eretn, 1'b1);
      checkBit("sys_eretn_eret", eret, 1'b0);
      tick();
      clearInputs();
      checkReg("sys_ie_on", 5'd12, 32'h0000_0001);
      applyStimulus(1'b1, 1'b1, 32'h104, 1'b0, 1'b0);
      tick();
      clearInputs();
      checkOutput("sys_sepc2", sepc, 32'h104);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      #1;
      checkBit("sys_both_eret", eret, 1'b1);
      checkBit("sys_both_eretn", eretn, 1'b0);
      tick();
      clearInputs();

      writeReg(5'd12, 32'h0);
      irq = 6'b000100;
      tick();
      irq = '0;
      tick();
      checkReg("col_ip_set", 5'd13, 32'h0000_0420);
      cp0We    = 1'b1;
      cp0Addr  = 5'd13;
      cp0Wdata = 32'h0;
      irq      = 6'b000100;
      tick();
      cp0We    = 1'b0;
      checkReg("col_ip_edge", 5'd13, 32'h0000_0420);
      irq = '0;
      writeReg(5'd13, 32'h0);
      checkReg("col_ip_clr", 5'd13, 32'h0000_0020);
      applyStimulus(1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
      cp0We    = 1'b1;
      cp0Addr  = 5'd12;
      cp0Wdata = 32'h0000_0001;
      tick();
      clearInputs();
      checkReg("col_ie_trap", 5'd12, 32'h0);
      checkOutput("col_trap_sepc", sepc, 32'h200);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      cp0We    = 1'b1;
      cp0Addr  = 5'd12;
      cp0Wdata = 32'h0;
      tick();
      clearInputs();
      checkReg("col_ie_ret", 5'd12, 32'h0000_0001);
      applyStimulus(1'b1, 1'b1, 32'h240, 1'b0, 1'b0);
      cp0We    = 1'b1;
      cp0Addr  = 5'd14;
      cp0Wdata = 32'hDEAD_BEEF;
      tick();
      clearInputs();
      checkOutput("col_epc", sepc, 32'h240);
      writeReg(5'd12, 32'h0000_0401);

      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      reset = 1'b1;
      #1;
      checkBit("rst_hdl_eret", eret, 1'b0);
      tick();
      reset = 1'b0;
      #1;
      checkBit("rst_hdl_run", eret, 1'b0);
      clearInputs();
      checkReg("rst_hdl_status", 5'd12, 32'h0);
      checkReg("rst_hdl_cause", 5'd13, 32'h0);
      checkReg("rst_hdl_epc", 5'd14, 32'h0);
      checkOutput("rst_hdl_sepc", sepc, 32'h0);

      writeReg(5'd12, 32'h0000_1001);
      irq = 6'b010000;
      tick();
      applyStimulus(1'b1, 1'b0, 32'h300, 1'b0, 1'b0);
      #1;
      checkBit("held_int", intSignal, 1'b1);
      tick();
      clearInputs();
      checkReg("held_cause", 5'd13, 32'h0004_0000);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      clearInputs();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b0, 32'h304 + 32'(k * 4), 1'b0, 1'b0);
         #1;
         checkBit("held_no_retrap", intSignal, 1'b0);
         tick();
      end
      clearInputs();
      applyStimulus(1'b1, 1'b1, 32'h400, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h404, 1'b0, 1'b0);
      #1;
      checkBit("held_no_retrap2", intSignal, 1'b0);
      clearInputs();
      irq = '0;
      tick();
      irq = 6'b010000;
      tick();
      applyStimulus(1'b1, 1'b0, 32'h408, 1'b0, 1'b0);
      #1;
      checkBit("held_repend", intSignal, 1'b1);
      tick();
      clearInputs();
      checkOutput("held_repend_sepc", sepc, 32'h408);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
